// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver with 16x oversampling, a 2-flop input
//                synchronizer, and a ready/valid output. Frame errors and
//                overruns are reported as single-cycle pulses.
//                Optional build macro UART_RX_FIFO_EN selects a 4-entry
//                FIFO in place of the single holding register.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  // Oversample divider. The divide ratio is clamped to at least 1 so that
  // odd parameter choices still elaborate.
  localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  // Receiver states.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // Input synchronizer and edge history.
  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;

  // Receiver datapath.
  logic [1:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;

  // Handshake / event qualifiers.
  logic             fall;
  logic             stop_sample;
  logic             deliver;
  logic             stop_bad;
  logic             pop;

  // Two-flop synchronizer; loads idle-high on reset so no false start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // A start is only a true 1->0 transition, so a line held low cannot retrigger.
  assign fall = rx_prev & ~rx_sync;

  // The divider only runs outside IDLE, so every frame starts from count 0.
  assign tick = (state != IDLE) && (div_cnt == DIV_LAST);

  // The stop bit is judged on the 16th tick of the STOP state.
  assign stop_sample = (state == STOP) && tick && (tick_cnt == 4'd15);
  assign deliver     = stop_sample &  rx_sync;
  assign stop_bad    = stop_sample & ~rx_sync;
  assign pop         = rx_valid & rx_ready;

  // Oversample divider: held at zero in IDLE, wraps on every tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (state == IDLE) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Frame state machine: mid-start check, eight data samples, stop check.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
          if (fall) begin
            state <= START;
          end
        end

        START: begin
          if (tick) begin
            if (tick_cnt == 4'd7) begin
              // Middle of the start bit: a high line here was just a glitch.
              tick_cnt <= '0;
              if (!rx_sync) begin
                state <= DATA;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end

        DATA: begin
          if (tick) begin
            // Counter wraps 15 -> 0, so each bit gets a full 16 ticks.
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd15) begin
              shift_reg <= {rx_sync, shift_reg[7:1]};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= STOP;
              end
            end
          end
        end

        STOP: begin
          if (tick) begin
            if (tick_cnt == 4'd15) begin
              tick_cnt <= '0;
              state    <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Frame error is a registered copy of the bad-stop qualifier (one cycle).
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= stop_bad;
    end
  end

`ifdef UART_RX_FIFO_EN

  // Four-entry FIFO; a pop frees a slot in the same cycle as a push.
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       full;
  logic       push;

  assign full = (count == 3'd4);
  assign push = deliver && (!full || pop);

  // FIFO storage, pointers, occupancy and overrun pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        fifo_mem[i] <= 8'h00;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= deliver && full && !pop;
      if (push) begin
        fifo_mem[wr_ptr] <= shift_reg;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  assign rx_data  = fifo_mem[rd_ptr];
  assign rx_valid = (count != 3'd0);

`else

  // Single holding register.
  logic [7:0] hold_data;
  logic       hold_valid;

  // Holding register: new byte wins only if the slot is free or being popped.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_data  <= 8'h00;
      hold_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (deliver) begin
        if (!hold_valid || pop) begin
          hold_data  <= shift_reg;
          hold_valid <= 1'b1;
        end else begin
          // Slot occupied and not draining: drop the new byte, keep the old.
          overrun <= 1'b1;
        end
      end else if (pop) begin
        hold_valid <= 1'b0;
      end
    end
  end

  assign rx_data  = hold_data;
  assign rx_valid = hold_valid;

`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. A vector table covers
//                clean and framing-error frames; hand sequences cover the
//                start glitch, overrun, same-cycle pop and mid-frame reset.
//                Honours UART_RX_FIFO_EN for the storage-dependent checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int BAUD      = 9600;
  localparam int CLK_HZ    = BAUD * 16 * 4;
  localparam int DIV       = 4;
  localparam int BIT_CLKS  = 16 * DIV;
  // Posedges from the start-bit drive to the edge before the stop sample:
  // 2 synchronizer edges + 1 detect edge, then 152 ticks of DIV clocks.
  localparam int POP_EDGES = 3 + 152 * DIV - 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor counters, written only by the monitor process.
  int         pop_cnt  = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt  = 0;
  int         long_cnt = 0;
  logic [7:0] last_pop = 8'h00;
  logic       prev_ferr = 1'b0;
  logic       prev_ovr  = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         exp_pops;
    int         exp_ferr;
  } vec_t;

  vec_t vecs [6];

  uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Observe handshakes and pulses on the falling edge.
  always @(negedge clk) begin
    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      pop_cnt  <= pop_cnt + 1;
      last_pop <= rx_data;
    end
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (overrun === 1'b1)   ovr_cnt  <= ovr_cnt + 1;
    if ((frame_err === 1'b1 && prev_ferr === 1'b1) ||
        (overrun === 1'b1 && prev_ovr === 1'b1)) long_cnt <= long_cnt + 1;
    prev_ferr <= frame_err;
    prev_ovr  <= overrun;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int b = 0; b < 8; b++) drive_bit(d[b]);
    drive_bit(stop_bit);
    rx = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  initial begin
    int         p0;
    int         f0;
    int         o0;
    logic [7:0] pd;

    vecs[0] = '{8'h30, 1'b1, 1, 0};
    vecs[1] = '{8'h55, 1'b0, 0, 1};
    vecs[2] = '{8'hA5, 1'b1, 1, 0};
    vecs[3] = '{8'h00, 1'b1, 1, 0};
    vecs[4] = '{8'hFF, 1'b1, 1, 0};
    vecs[5] = '{8'h81, 1'b1, 1, 0};

    // Reset state.
    reset    = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("reset rx_valid",  32'(rx_valid),  32'd0);
    check("reset rx_data",   32'(rx_data),   32'h00);
    check("reset frame_err", 32'(frame_err), 32'd0);
    check("reset overrun",   32'(overrun),   32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Table: clean frames and a framing error, consumer always ready.
    for (int i = 0; i < 6; i++) begin
      rx_ready = 1'b1;
      p0 = pop_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
      send_byte(vecs[i].data, vecs[i].stop_bit);
      repeat (8) @(negedge clk);
      check($sformatf("vec%0d pops", i), 32'(pop_cnt - p0), 32'(vecs[i].exp_pops));
      if (vecs[i].exp_pops != 0)
        check($sformatf("vec%0d data", i), 32'(last_pop), 32'(vecs[i].data));
      check($sformatf("vec%0d frame_err", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d overrun", i),   32'(ovr_cnt - o0),  32'd0);
      check($sformatf("vec%0d idle valid", i), 32'(rx_valid),     32'd0);
    end

    // Start-bit glitch of 4 ticks, then a normal frame.
    p0 = pop_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    repeat (4 * DIV) @(negedge clk);
    rx = 1'b1;
    repeat (20 * DIV) @(negedge clk);
    check("glitch pops",      32'(pop_cnt - p0),  32'd0);
    check("glitch frame_err", 32'(ferr_cnt - f0), 32'd0);
    check("glitch valid",     32'(rx_valid),      32'd0);
    send_byte(8'h30, 1'b1);
    repeat (8) @(negedge clk);
    check("post-glitch pops", 32'(pop_cnt - p0), 32'd1);
    check("post-glitch data", 32'(last_pop),     32'h30);

    // Overrun: two bytes with nobody consuming.
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    repeat (8) @(negedge clk);
    check("ovr valid", 32'(rx_valid), 32'd1);
    check("ovr data",  32'(rx_data),  32'h41);
`ifdef UART_RX_FIFO_EN
    check("fifo no overrun", 32'(ovr_cnt - o0), 32'd0);
    rx_ready = 1'b1;
    @(negedge clk);
    check("fifo second data",  32'(rx_data),  32'h42);
    check("fifo second valid", 32'(rx_valid), 32'd1);
    @(negedge clk);
    rx_ready = 1'b0;
    check("fifo drained", 32'(rx_valid), 32'd0);
`else
    check("hold overrun pulses", 32'(ovr_cnt - o0), 32'd1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("hold drained", 32'(rx_valid), 32'd0);
`endif

    // Pop the held 0x10 on exactly the cycle 0x11 is delivered.
    o0 = ovr_cnt;
    send_byte(8'h10, 1'b1);
    check("held 0x10", 32'(rx_data), 32'h10);
    fork
      send_byte(8'h11, 1'b1);
      begin
        repeat (POP_EDGES) @(posedge clk);
        @(negedge clk);
        check("pre-pop valid", 32'(rx_valid), 32'd1);
        check("pre-pop data",  32'(rx_data),  32'h10);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("same-cycle valid",   32'(rx_valid), 32'd1);
        check("same-cycle data",    32'(rx_data),  32'h11);
        check("same-cycle overrun", 32'(overrun),  32'd0);
      end
    join
    check("same-cycle no overrun", 32'(ovr_cnt - o0), 32'd0);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("0x11 drained", 32'(rx_valid), 32'd0);

    // Reset during data bit 4 with a byte held, then a clean frame.
    send_byte(8'h5A, 1'b1);
    check("pre-reset held", 32'(rx_data), 32'h5A);
    pd = 8'h7A;
    drive_bit(1'b0);
    for (int b = 0; b < 4; b++) drive_bit(pd[b]);
    rx = pd[4];
    repeat (BIT_CLKS / 2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("mid reset valid", 32'(rx_valid), 32'd0);
    check("mid reset data",  32'(rx_data),  32'h00);
    reset = 1'b0;
    rx    = 1'b1;
    repeat (BIT_CLKS * 2) @(negedge clk);
    check("post-reset valid", 32'(rx_valid), 32'd0);
    rx_ready = 1'b1;
    p0 = pop_cnt; f0 = ferr_cnt;
    send_byte(8'h7A, 1'b1);
    repeat (8) @(negedge clk);
    check("post-reset pops",      32'(pop_cnt - p0),  32'd1);
    check("post-reset data",      32'(last_pop),      32'h7A);
    check("post-reset frame_err", 32'(ferr_cnt - f0), 32'd0);

    check("single-cycle pulses", 32'(long_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock port `clk`, reset port `reset`.
REQ-002 Parameter `CLK_HZ`, default 100_000_000, SHALL give the system clock frequency in Hz.
REQ-003 Parameter `BAUD`, default 9600, SHALL give the line bit rate.
REQ-004 Port `clk`, input, 1 bit: system clock; all logic SHALL be on its rising edge.
REQ-005 Port `reset`, input, 1 bit: synchronous active-high reset.
REQ-006 Port `rx`, input, 1 bit: asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-007 Port `rx_data`, output, 8 bits: received byte, valid while `rx_valid`=1.
REQ-008 Port `rx_valid`, output, 1 bit: a byte is available.
REQ-009 Port `rx_ready`, input, 1 bit: the consumer accepts `rx_data` on any cycle where `rx_valid`=1 and `rx_ready`=1.
REQ-010 Port `frame_err`, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-011 Port `overrun`, output, 1 bit: one-cycle pulse when a completed byte is dropped for lack of storage.

Function
REQ-012 `rx` SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value.
REQ-013 The oversample tick SHALL be a 1-cycle pulse every DIV = CLK_HZ/(BAUD*16) clocks (integer division; 651 at defaults); the divider SHALL restart at 0 on leaving IDLE.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-015 IDLE→START SHALL occur only on a falling edge of synchronized `rx` (previous 1, current 0); a held-low line SHALL NOT retrigger.
REQ-016 START: at tick 8, if `rx`=0 go to DATA with the tick count cleared; if `rx`=1 (glitch) return to IDLE with no output.
REQ-017 DATA: every 16th tick SHALL sample one bit into a shift register, LSB first; after bit 7 go to STOP.
REQ-018 STOP: at the 16th tick, if `rx`=1 deliver the byte and go to IDLE; if `rx`=0 pulse `frame_err`, discard the byte and go to IDLE.
REQ-019 A delivered byte SHALL appear on `rx_data` with `rx_valid`=1 on the clock after the stop-bit sample.
REQ-020 `rx_data` SHALL be stable while `rx_valid`=1 and not popped.
REQ-021 On delivery with storage full and no simultaneous pop, the new byte SHALL be dropped, `overrun` SHALL pulse, and the stored data SHALL be unchanged.
REQ-022 On delivery in the same cycle as a pop, the new byte SHALL be stored; `rx_valid` stays 1 and there is no overrun.
REQ-023 `frame_err` and `overrun` SHALL never be asserted for more than one cycle per event.

Reset
REQ-024 On `reset`=1 at a clock edge, the FSM SHALL go to IDLE and the divider, bit counter and storage SHALL clear.
REQ-025 On reset, outputs SHALL be `rx_valid`=0, `rx_data`=8'h00, `frame_err`=0, `overrun`=0, and the synchronizer flops SHALL load 1.
REQ-026 Reset mid-frame SHALL abandon the frame; the next clean start bit SHALL be received normally.

Configuration
REQ-027 Macro `UART_RX_FIFO_EN` defined: storage SHALL be a 4-entry FIFO, output in arrival order; `rx_valid` = not empty; overrun only when 4 entries are held.
REQ-028 Macro `UART_RX_FIFO_EN` undefined: storage SHALL be a single holding register; overrun when it is occupied.

Verification
REQ-029 Bench: send 0x30 at 9600 baud, `rx_ready`=1 → `rx_valid` pulses for 1 cycle with `rx_data`=0x30, no error pulses.
REQ-030 Bench: drive `rx` low for 4 ticks, then high → no `rx_valid`, no `frame_err`, FSM back in IDLE.
REQ-031 Bench: send 0x55 with stop bit 0 → one `frame_err` pulse, `rx_valid` stays 0.
REQ-032 Bench: send 0x41 then 0x42, `rx_ready`=0 → without FIFO, `overrun` pulses once and `rx_data` stays 0x41; with FIFO, pops yield 0x41 then 0x42.
REQ-033 Bench: assert `reset` during data bit 4, then send 0x7A → `rx_valid`=0 after reset, then 0x7A is received correctly.
REQ-034 Bench: hold 0x10, pop in the same cycle that 0x11 completes → `rx_data`=0x11, `rx_valid`=1, no `overrun`.
